fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: owns the program counter and drives the instruction-memory request/acknowledge handshake. It presents each fetched instruction and its PC to the IF/ID pipeline register with a valid flag. It absorbs downstream stalls with a one-entry holding buffer and turns branch/jump redirects into a PC reload plus a flush pulse for the IF/ID register.

## Interface
- WIDTH, 32, PC/instruction/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- stall_in  input  1  downstream cannot accept; hold current output.
- redirect_in  input  1  branch/jump taken; reload PC.
- redirect_pc_in  input  WIDTH  redirect target.
- imem_req_out  output  1  instruction-memory request.
- imem_addr_out  output  WIDTH  fetch address (= internal pc_q).
- imem_ack_in  input  1  memory returns data this cycle.
- imem_rdata_in  input  WIDTH  fetched instruction, valid with ack.
- pc_out  output  WIDTH  PC of presented instruction.
- instr_out  output  WIDTH  presented instruction.
- valid_out  output  1  pc_out/instr_out hold a real instruction.
- flush_out  output  1  drives IF/ID flush; equals redirect_in, forced 0 while rst_in=1.

## Operation
- Reset values:
  - Internal registers: pc_q=RESET_PC, state=IDLE, buffer invalid.
  - Outputs: pc_out=0, instr_out=NOP (32'h0000_0013), valid_out=0, imem_req_out=0.
- "Slot free" = !valid_out || !stall_in; the presented instruction is consumed on any edge where valid_out && !stall_in.
- IDLE: imem_req_out=0. Always moves to REQ on the next edge.
- REQ:
  - Drives imem_req_out=1, imem_addr_out=pc_q; the request stays asserted with a stable address until ack.
  - On ack with slot free: pc_out<=pc_q, instr_out<=rdata, valid_out<=1, pc_q<=pc_q+4; stay in REQ.
  - On ack with slot occupied: buffer<={pc_q, rdata}, pc_q<=pc_q+4; go to HOLD.
  - Without ack, if the current output is consumed: valid_out<=0, instr_out<=NOP.
- HOLD:
  - imem_req_out=0.
  - When stall_in=0: outputs<=buffer, valid_out<=1, buffer invalid; go to REQ.
- Redirect has highest priority in every state:
  - pc_q<=redirect_pc_in, valid_out<=0, instr_out<=NOP, buffer invalid, next state REQ.
  - An ack in the same cycle is discarded.
  - Memory must tolerate an address change while a request is pending, abandoning the old request.
- PC increment wraps modulo 2^WIDTH: 32'hFFFF_FFFC+4 = 0.
- Reset overrides redirect and ack; a reset mid-request drops the request in the next cycle.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, instr_out valid one edge after the ack.
- Fetch of RESET_PC is requested in cycle 2 after reset deasserts (IDLE occupies cycle 1).
- Redirect to first request at the new PC: 0 cycles; imem_addr_out shows the new PC the cycle after redirect_in.
- N-cycle memory: valid_out low for the cycles between presented instructions.
- flush_out is combinational from redirect_in, with no register stage.

## Configuration
- FETCH_MISALIGN_EN:
  - Defined:
    - Adds port misalign_out (output, 1).
    - A redirect with redirect_pc_in[1:0]≠0 moves the FSM to state ERR: no requests issued, valid_out=0, misalign_out=1 (registered, sticky).
    - ERR persists until the next aligned redirect or reset.
  - Undefined:
    - redirect_pc_in[1:0] is ignored (forced to 2'b00).
    - There is no ERR state and no misalign_out port.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INSTR (32'h0000_0013)
  - INSTR_BYTES (4)
  - typedef enum fetch_state_t {IDLE, REQ, HOLD, ERR}; ERR is used only under the macro.
- One natural sub-module: fetch_skid, the single-entry {pc, instr} holding buffer with load/drain/clear.

## Test plan
- Reset, then zero-wait memory returning rdata=addr^32'hA5A5_A5A5 → imem_addr_out 0,4,8,…; pc_out/instr_out follow one edge later, valid_out continuous.
- stall_in=1 for 3 cycles while valid_out=1 and an ack arrives → outputs frozen, FSM in HOLD, req=0. When stall drops, the buffered PC+4 instruction is presented next edge, then fetch resumes at PC+8.
- redirect_in with redirect_pc_in=32'h0000_0100 in the same cycle as an ack → flush_out=1 that cycle, ack data dropped, valid_out=0 next edge, next request address 0x100.
- Memory with 2-cycle ack latency → req held with a stable address; valid_out pulses once every 3 cycles.
- RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- With FETCH_MISALIGN_EN: redirect to 32'h0000_0102 → misalign_out=1, no requests. A subsequent redirect to 0x200 clears misalign_out and fetches 0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch stage.
// ERR is only reached when FETCH_MISALIGN_EN is defined.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry {pc, instr} holding buffer.
// Fetches that arrive while the downstream stage is stalled are parked here.
module fetch_skid
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic             drain_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out
);

  logic             valid_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= WIDTH'(NOP_INSTR);
    end else if (clear_in || drain_in) begin
      valid_q <= 1'b0;
    end else if (load_in) begin
      valid_q <= 1'b1;
      pc_q    <= pc_in;
      instr_q <= instr_in;
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, one-entry stall buffer, redirect/flush.
// Optional FETCH_MISALIGN_EN adds misalign_out and a sticky ERR state.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_ack_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out,
  output logic             flush_out
`ifdef FETCH_MISALIGN_EN
  ,
  output logic             misalign_out
`endif
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] redir_pc;
  logic [WIDTH-1:0] pc_inc;
  logic             slot_free;
  logic             consumed;
  logic             skid_load, skid_drain, skid_clear;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_pc, skid_instr;
`ifdef FETCH_MISALIGN_EN
  logic             misalign_q, misalign_d;
  logic             redir_misaligned;

  assign redir_pc         = redirect_pc_in;
  assign redir_misaligned = (redirect_pc_in[1:0] != 2'b00);
`else
  // Low address bits are dropped so every fetch stays word aligned.
  assign redir_pc = redirect_pc_in & ~WIDTH'(3);
`endif

  assign pc_inc    = pc_q + WIDTH'(INSTR_BYTES);
  assign slot_free = !out_valid_q || !stall_in;
  assign consumed  = out_valid_q && !stall_in;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;
`ifdef FETCH_MISALIGN_EN
    misalign_d  = misalign_q;
`endif

    if (redirect_in) begin
      // Redirect wins over everything; an ack in this cycle is dropped.
      pc_d        = redir_pc;
      out_valid_d = 1'b0;
      out_instr_d = WIDTH'(NOP_INSTR);
      skid_clear  = 1'b1;
      state_d     = REQ;
`ifdef FETCH_MISALIGN_EN
      misalign_d  = redir_misaligned;
      if (redir_misaligned) begin
        state_d = ERR;
      end
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ack_in) begin
            pc_d = pc_inc;
            if (slot_free) begin
              out_pc_d    = pc_q;
              out_instr_d = imem_rdata_in;
              out_valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (consumed) begin
            out_valid_d = 1'b0;
            out_instr_d = WIDTH'(NOP_INSTR);
          end
        end
        HOLD: begin
          if (!stall_in) begin
            out_pc_d    = skid_pc;
            out_instr_d = skid_instr;
            out_valid_d = skid_valid;
            skid_drain  = 1'b1;
            state_d     = REQ;
          end
        end
`ifdef FETCH_MISALIGN_EN
        ERR: begin
          out_valid_d = 1'b0;
          out_instr_d = WIDTH'(NOP_INSTR);
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= WIDTH'(NOP_INSTR);
      out_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
`ifdef FETCH_MISALIGN_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  fetch_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (skid_load),
    .drain_in  (skid_drain),
    .clear_in  (skid_clear),
    .pc_in     (pc_q),
    .instr_in  (imem_rdata_in),
    .valid_out (skid_valid),
    .pc_out    (skid_pc),
    .instr_out (skid_instr)
  );

  assign imem_req_out  = (state_q == REQ);
  assign imem_addr_out = pc_q;
  assign pc_out        = out_pc_q;
  assign instr_out     = out_instr_q;
  assign valid_out     = out_valid_q;
  assign flush_out     = redirect_in && !rst_in;
`ifdef FETCH_MISALIGN_EN
  assign misalign_out  = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus latency, wrap, reset and misalign sequences.
module tb_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_flush;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, ack_drv, lat_mode;
  logic [31:0] rpc;
  logic [1:0]  cnt;
  logic        req, valid, flush, ack;
  logic [31:0] addr, pc, instr, rdata;
  logic        req2, valid2, flush2;
  logic [31:0] addr2, pc2, instr2;
`ifdef FETCH_MISALIGN_EN
  logic        misalign, misalign2;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vec[19];
  logic [31:0] wrap_exp[4];
  logic [31:0] base;

  always #5 clk = ~clk;

  assign rdata = addr ^ K;
  assign ack   = lat_mode ? (req && cnt == 2'd2) : ack_drv;

  always @(posedge clk) begin
    if (lat_mode && req && !ack) cnt <= cnt + 2'd1;
    else cnt <= 2'd0;
  end

  fetch_unit dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .stall_in       (stall),
    .redirect_in    (redirect),
    .redirect_pc_in (rpc),
    .imem_req_out   (req),
    .imem_addr_out  (addr),
    .imem_ack_in    (ack),
    .imem_rdata_in  (rdata),
    .pc_out         (pc),
    .instr_out      (instr),
    .valid_out      (valid),
    .flush_out      (flush)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_out   (misalign)
`endif
  );

  // Second instance exercises PC wrap with a zero-wait memory.
  fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut2 (
    .clk_in         (clk),
    .rst_in         (rst),
    .stall_in       (1'b0),
    .redirect_in    (1'b0),
    .redirect_pc_in (32'h0),
    .imem_req_out   (req2),
    .imem_addr_out  (addr2),
    .imem_ack_in    (req2),
    .imem_rdata_in  (addr2 ^ K),
    .pc_out         (pc2),
    .instr_out      (instr2),
    .valid_out      (valid2),
    .flush_out      (flush2)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_out   (misalign2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic a, input logic eq, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                              input logic ef);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ack = a; v.e_req = eq; v.e_addr = ea;
    v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_flush = ef;
    return v;
  endfunction

  initial begin
    //           stall red rpc       ack req addr      val pc        instr           flush
    vec[0]  = mk(0, 0, 32'h0,   0, 0, 32'h000, 0, 32'h000, NOP,            0);
    vec[1]  = mk(0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h000, NOP,            0);
    vec[2]  = mk(0, 0, 32'h0,   1, 1, 32'h004, 1, 32'h000, 32'h000 ^ K,    0);
    vec[3]  = mk(0, 0, 32'h0,   1, 1, 32'h008, 1, 32'h004, 32'h004 ^ K,    0);
    vec[4]  = mk(1, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h008, 32'h008 ^ K,    0);
    vec[5]  = mk(1, 0, 32'h0,   0, 0, 32'h010, 1, 32'h008, 32'h008 ^ K,    0);
    vec[6]  = mk(1, 0, 32'h0,   0, 0, 32'h010, 1, 32'h008, 32'h008 ^ K,    0);
    vec[7]  = mk(0, 0, 32'h0,   0, 0, 32'h010, 1, 32'h008, 32'h008 ^ K,    0);
    vec[8]  = mk(0, 0, 32'h0,   1, 1, 32'h010, 1, 32'h00C, 32'h00C ^ K,    0);
    vec[9]  = mk(0, 1, 32'h100, 1, 1, 32'h014, 1, 32'h010, 32'h010 ^ K,    1);
    vec[10] = mk(0, 0, 32'h0,   0, 1, 32'h100, 0, 32'h000, NOP,            0);
    vec[11] = mk(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h000, NOP,            0);
    vec[12] = mk(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100, 32'h100 ^ K,    0);
    vec[13] = mk(0, 0, 32'h0,   0, 1, 32'h104, 0, 32'h000, NOP,            0);
    vec[14] = mk(1, 0, 32'h0,   0, 1, 32'h104, 0, 32'h000, NOP,            0);
    vec[15] = mk(1, 0, 32'h0,   1, 1, 32'h104, 0, 32'h000, NOP,            0);
    vec[16] = mk(1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h104, 32'h104 ^ K,    0);
    vec[17] = mk(1, 1, 32'h200, 0, 0, 32'h10C, 1, 32'h104, 32'h104 ^ K,    1);
    vec[18] = mk(0, 0, 32'h0,   0, 1, 32'h200, 0, 32'h000, NOP,            0);
    wrap_exp[0] = 32'h0; wrap_exp[1] = 32'hFFFF_FFF8;
    wrap_exp[2] = 32'hFFFF_FFFC; wrap_exp[3] = 32'h0000_0000;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = '0; ack_drv = 1'b0; lat_mode = 1'b0;
    cnt = 2'd0;
    repeat (3) @(negedge clk);
    redirect = 1'b1; rpc = 32'h40;
    #1;
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, NOP);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = 1'b0;
      stall = vec[i].stall; redirect = vec[i].redir; rpc = vec[i].rpc; ack_drv = vec[i].ack;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vec[i].e_req});
      chk($sformatf("v%0d_addr", i), addr, vec[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vec[i].e_valid});
      chk($sformatf("v%0d_instr", i), instr, vec[i].e_instr);
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vec[i].e_flush});
      if (vec[i].e_valid) chk($sformatf("v%0d_pc", i), pc, vec[i].e_pc);
      if (i == 0) chk("wrap_idle_req", {31'b0, req2}, 32'd0);
      else if (i < 4) chk($sformatf("wrap_addr%0d", i), addr2, wrap_exp[i]);
    end

`ifdef FETCH_MISALIGN_EN
    @(negedge clk);
    redirect = 1'b1; rpc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("mis_set", {31'b0, misalign}, 32'd1);
    chk("mis_req", {31'b0, req}, 32'd0);
    chk("mis_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mis_sticky", {31'b0, misalign}, 32'd1);
    chk("mis_req2", {31'b0, req}, 32'd0);
    @(negedge clk);
    redirect = 1'b1; rpc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("mis_clear", {31'b0, misalign}, 32'd0);
    chk("mis_resume_req", {31'b0, req}, 32'd1);
    chk("mis_resume_addr", addr, 32'h200);
    base = 32'h200;
`else
    @(negedge clk);
    redirect = 1'b1; rpc = 32'h0000_0303;
    #1;
    chk("lowbits_flush", {31'b0, flush}, 32'd1);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("lowbits_addr", addr, 32'h300);
    chk("lowbits_req", {31'b0, req}, 32'd1);
    base = 32'h300;
`endif

    // Two-cycle memory latency: address stable for 3 cycles, valid once per 3.
    lat_mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("lat%0d_addr", k), addr, base + 32'(4 * (k / 3)));
      chk($sformatf("lat%0d_req", k), {31'b0, req}, 32'd1);
      chk($sformatf("lat%0d_valid", k), {31'b0, valid},
          {31'b0, (k >= 3 && k % 3 == 0)});
      if (k >= 3 && k % 3 == 0)
        chk($sformatf("lat%0d_instr", k), instr, (base + 32'(4 * (k / 3 - 1))) ^ K);
    end

    // Reset mid-request: request still up this cycle, gone the next.
    @(negedge clk);
    lat_mode = 1'b0; ack_drv = 1'b0; rst = 1'b1; redirect = 1'b1; rpc = 32'h80;
    #1;
    chk("midrst_flush", {31'b0, flush}, 32'd0);
    chk("midrst_req_now", {31'b0, req}, 32'd1);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("midrst_req_next", {31'b0, req}, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_instr", instr, NOP);
    chk("midrst_addr", addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
